// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA pipe-map display.
//  - 640x480@60 timing constants (visible area, front porch, back porch, retrace)
//  - tile geometry of the pipe map
//  - tile_t encoding stored in the map RAM
//  - 24-bit (8 bits per channel) colour constants, packed {R,G,B}
// -----------------------------------------------------------------------------
package vga_pkg;

    // Horizontal timing, in pixels
    localparam int HD = 640;
    localparam int HF = 16;
    localparam int HB = 48;
    localparam int HR = 96;

    // Vertical timing, in lines
    localparam int VD = 480;
    localparam int VF = 10;
    localparam int VB = 33;
    localparam int VR = 2;

    // Tile map geometry
    localparam int TILE_LOG = 5;
    localparam int MAP_COLS = 20;
    localparam int MAP_ROWS = 15;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PIPE  = 2'd1,
        DIRT  = 2'd2,
        WALL  = 2'd3
    } tile_t;

    // Colours, {R,G,B}
    localparam logic [23:0] COL_BLACK = 24'h000000;
    localparam logic [23:0] COL_PIPE  = 24'h0000C0;
    localparam logic [23:0] COL_DIRT  = 24'h804000;
    localparam logic [23:0] COL_WALL  = 24'hFFFFFF;
    localparam logic [23:0] COL_GRID  = 24'h404040;
    localparam logic [23:0] COL_ROBOT = 24'hFFFF00;

endpackage

// File: rtl/tile_map_ram.sv
// -----------------------------------------------------------------------------
// tile_map_ram
// Simple dual-port RAM holding one tile type per map cell.
//  clk     in        clock
//  we      in        write strobe, accepted on any cycle
//  waddr   in  AW    write address; addresses >= DEPTH are ignored
//  wdata   in  DW    write data
//  re      in        read enable (advances the registered read port)
//  raddr   in  AW    read address; addresses >= DEPTH read as 0
//  rdata   out DW    registered read data, valid the cycle after re
// A read and a write to the same address on the same edge return the old
// contents: both use non-blocking assignment on the same array, which is
// the read-first behaviour block RAMs provide natively.
// -----------------------------------------------------------------------------
module tile_map_ram #(
    parameter int DEPTH = 300,
    parameter int AW    = 9,
    parameter int DW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [DW-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we && (waddr <= LAST_ADDR)) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= (raddr <= LAST_ADDR) ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/vga_tile_renderer.sv
// -----------------------------------------------------------------------------
// vga_tile_renderer
// Pixel stage behind the VGA sync generator: draws the 20x15 tile map
// (32x32-pixel tiles), 1-pixel grid lines and the robot sprite, and re-times
// the sync/blank signals so every VGA output carries a 2-pixel-tick latency.
//  CLOCK_50     in          system clock
//  reset        in          synchronous, active-high
//  p_tick       in          pixel enable; the pipeline only advances when high
//  video_on     in          active-area flag
//  pixel_x/y    in   10     current pixel position
//  hsync_in     in          registered HS, active-low
//  vsync_in     in          registered VS, active-low
//  map_we       in          map write strobe (any cycle)
//  map_addr     in   9      tile index row*20+col; >= 300 ignored
//  map_wdata    in   2      tile_t value
//  robot_col    in   5      robot tile column
//  robot_row    in   4      robot tile row
//  VGA_R/G/B    out  COLOR_W
//  VGA_HS/VS    out         delayed hsync_in / vsync_in
//  VGA_BLANK_N  out         delayed video_on
// Pipeline (each stage moves on p_tick only):
//  stage 1: tile address to RAM, fine offsets, tile col/row, video/sync
//  stage 2: colour mux using RAM data, registered onto the pins
// -----------------------------------------------------------------------------
module vga_tile_renderer
    import vga_pkg::*;
#(
    parameter int COLOR_W   = 8,
    parameter int TILE_LOG  = 5,
    parameter int MAP_COLS  = 20,
    parameter int MAP_ROWS  = 15,
    parameter int ROBOT_INS = 4
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               p_tick,
    input  logic               video_on,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               map_we,
    input  logic [8:0]         map_addr,
    input  logic [1:0]         map_wdata,
    input  logic [4:0]         robot_col,
    input  logic [3:0]         robot_row,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N
);

    // Width of a tile coordinate taken from the top bits of pixel_x/pixel_y
    localparam int CW = 10 - TILE_LOG;

    // Sprite window bounds inside a tile, one bit wider so a zero inset works
    localparam logic [TILE_LOG:0] INS_LO = (TILE_LOG + 1)'(ROBOT_INS);
    localparam logic [TILE_LOG:0] INS_HI = (TILE_LOG + 1)'((1 << TILE_LOG) - ROBOT_INS);

    // ------------------------------------------------------------------
    // Tile address: row*20 + col as (row<<4) + (row<<2) + col.
    // Lines past the map (y >= 480) may exceed 299; the RAM returns 0 for
    // those and they are always blanked anyway.
    // ------------------------------------------------------------------
    logic [CW-1:0] tile_col;
    logic [CW-1:0] tile_row;
    logic [8:0]    rd_addr;
    logic [1:0]    rd_data;

    assign tile_col = pixel_x[9:TILE_LOG];
    assign tile_row = pixel_y[9:TILE_LOG];
    assign rd_addr  = 9'((10'(tile_row) << 4) + (10'(tile_row) << 2) + 10'(tile_col));

    tile_map_ram #(
        .DEPTH (MAP_COLS * MAP_ROWS),
        .AW    (9),
        .DW    (2)
    ) u_map (
        .clk   (CLOCK_50),
        .we    (map_we),
        .waddr (map_addr),
        .wdata (map_wdata),
        .re    (p_tick),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // ------------------------------------------------------------------
    // Stage 1 registers, aligned with the RAM read data
    // ------------------------------------------------------------------
    logic [TILE_LOG-1:0] s1_px;
    logic [TILE_LOG-1:0] s1_py;
    logic [CW-1:0]       s1_col;
    logic [CW-1:0]       s1_row;
    logic                s1_video;
    logic                s1_hs;
    logic                s1_vs;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1_px    <= '0;
            s1_py    <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
            s1_video <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
        end else if (p_tick) begin
            s1_px    <= pixel_x[TILE_LOG-1:0];
            s1_py    <= pixel_y[TILE_LOG-1:0];
            s1_col   <= tile_col;
            s1_row   <= tile_row;
            s1_video <= video_on;
            s1_hs    <= hsync_in;
            s1_vs    <= vsync_in;
        end
    end

    // ------------------------------------------------------------------
    // Robot shadow: only refreshed at the first tick of vertical blank so
    // a position change from game logic never splits a frame.
    // ------------------------------------------------------------------
    logic [4:0] shadow_col;
    logic [3:0] shadow_row;
    logic       frame_edge;

    assign frame_edge = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'(VD));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            shadow_col <= '0;
            shadow_row <= '0;
        end else if (frame_edge) begin
            shadow_col <= robot_col;
            shadow_row <= robot_row;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 colour mux: blank > robot > grid > tile type
    // ------------------------------------------------------------------
    logic        robot_hit;
    logic        grid_hit;
    logic [23:0] pix_rgb;

    assign robot_hit = (s1_col == CW'(shadow_col)) && (s1_row == CW'(shadow_row))
                    && ({1'b0, s1_px} >= INS_LO) && ({1'b0, s1_px} < INS_HI)
                    && ({1'b0, s1_py} >= INS_LO) && ({1'b0, s1_py} < INS_HI);
    assign grid_hit  = (s1_px == '0) || (s1_py == '0);

    always_comb begin
        pix_rgb = COL_BLACK;
        if (!s1_video) begin
            pix_rgb = COL_BLACK;
        end else if (robot_hit) begin
            pix_rgb = COL_ROBOT;
        end else if (grid_hit) begin
            pix_rgb = COL_GRID;
        end else begin
            case (tile_t'(rd_data))
                EMPTY:   pix_rgb = COL_BLACK;
                PIPE:    pix_rgb = COL_PIPE;
                DIRT:    pix_rgb = COL_DIRT;
                WALL:    pix_rgb = COL_WALL;
                default: pix_rgb = COL_BLACK;
            endcase
        end
    end

    // Fit an 8-bit channel to COLOR_W: narrower keeps the MSBs, wider
    // repeats the 8-bit pattern into the low bits.
    function automatic logic [COLOR_W-1:0] fit_chan(input logic [7:0] c);
        logic [COLOR_W-1:0] r;
        r = '0;
        for (int i = 0; i < COLOR_W; i++) begin
            r[COLOR_W-1-i] = c[7 - (i % 8)];
        end
        return r;
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
        end else if (p_tick) begin
            VGA_R       <= fit_chan(pix_rgb[23:16]);
            VGA_G       <= fit_chan(pix_rgb[15:8]);
            VGA_B       <= fit_chan(pix_rgb[7:0]);
            VGA_HS      <= s1_hs;
            VGA_VS      <= s1_vs;
            VGA_BLANK_N <= s1_video;
        end
    end

endmodule
